// File: rtl/fft_pkg.sv
// Shared FFT types, radix-4 twiddle constants and the round/saturate helpers.
// Helpers work on 64-bit signed values so any operand width up to 32 bits can use them.
package fft_pkg;

    localparam int FULL_WIDTH = 32;
    localparam int WIDTH      = FULL_WIDTH / 2;

    typedef struct packed {
        logic signed [WIDTH-1:0] re;
        logic signed [WIDTH-1:0] im;
    } cplx_t;

    localparam cplx_t W0_4 = '{re: WIDTH'(32767),  im: WIDTH'(0)};
    localparam cplx_t W1_4 = '{re: WIDTH'(0),      im: WIDTH'(-32768)};
    localparam cplx_t W2_4 = '{re: WIDTH'(-32768), im: WIDTH'(0)};

    // Clamp x to the signed range of a w-bit number.
    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            sat = hi;
        else if (x < lo)
            sat = lo;
        else
            sat = x;
    endfunction

    // Round half up, then arithmetic shift right by 'shift'.
    function automatic logic signed [63:0] round_q(input logic signed [63:0] x, input int shift);
        round_q = (x + (64'sd1 <<< (shift - 1))) >>> shift;
    endfunction

endpackage

// File: rtl/butterfly_radix4_if.sv
// Sample/twiddle input bundle and result output bundle of one radix-4 butterfly.
interface butterfly_radix4_if #(
    parameter int FULL_WIDTH = fft_pkg::FULL_WIDTH
);
    logic                  in_valid;
    logic [FULL_WIDTH-1:0] a, b, c, d;
    logic [FULL_WIDTH-1:0] w0, w1, w2, w3;
    logic [FULL_WIDTH-1:0] out0, out1, out2, out3;
    logic                  out_valid;

    modport master (
        output in_valid, a, b, c, d, w0, w1, w2, w3,
        input  out0, out1, out2, out3, out_valid
    );

    modport slave (
        input  in_valid, a, b, c, d, w0, w1, w2, w3,
        output out0, out1, out2, out3, out_valid
    );
endinterface

// File: rtl/butterfly_radix4_complex_mult.sv
// Combinational complex multiply x*w with Q1.15-style round-half-up and saturation.
module complex_mult #(
    parameter int WIDTH = fft_pkg::WIDTH
) (
    input  logic [2*WIDTH-1:0] x,
    input  logic [2*WIDTH-1:0] w,
    output logic [2*WIDTH-1:0] p
);
    import fft_pkg::*;

    localparam int PW = 2 * WIDTH + 1;

    logic signed [WIDTH-1:0] xr, xi, wr, wi;
    logic signed [PW-1:0]    re_full, im_full;
    logic signed [WIDTH-1:0] re_s, im_s;

    always_comb begin
        xr = x[2*WIDTH-1:WIDTH];
        xi = x[WIDTH-1:0];
        wr = w[2*WIDTH-1:WIDTH];
        wi = w[WIDTH-1:0];
        // One extra bit over 2*WIDTH holds the (-1)*(-1) + (-1)*(-1) extreme exactly.
        re_full = PW'(xr) * PW'(wr) - PW'(xi) * PW'(wi);
        im_full = PW'(xr) * PW'(wi) + PW'(xi) * PW'(wr);
        re_s = WIDTH'(sat(round_q(64'(re_full), WIDTH - 1), WIDTH));
        im_s = WIDTH'(sat(round_q(64'(im_full), WIDTH - 1), WIDTH));
        p = {re_s, im_s};
    end
endmodule

// File: rtl/butterfly_radix4.sv
// Two-stage radix-4 DIT butterfly: stage 1 holds twiddled products, stage 2 the
// saturated combine results. No backpressure; one butterfly per clock.
module butterfly_radix4 #(
    parameter int FULL_WIDTH = fft_pkg::FULL_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    butterfly_radix4_if.slave bus
);
    import fft_pkg::*;

    localparam int HW = FULL_WIDTH / 2;
    localparam int SW = HW + 2;

    logic [FULL_WIDTH-1:0] x_in   [4];
    logic [FULL_WIDTH-1:0] w_in   [4];
    logic [FULL_WIDTH-1:0] prod   [4];
    logic [FULL_WIDTH-1:0] prod_d [4];
    logic [FULL_WIDTH-1:0] prod_q [4];
    logic [FULL_WIDTH-1:0] out_d  [4];
    logic [FULL_WIDTH-1:0] out_q  [4];
    logic                  valid_s1_d, valid_s1_q;
    logic                  out_valid_d, out_valid_q;

    logic signed [SW-1:0]  pr [4];
    logic signed [SW-1:0]  pi [4];
    logic signed [SW-1:0]  sr [4];
    logic signed [SW-1:0]  si [4];

    always_comb begin
        x_in[0] = bus.a;  x_in[1] = bus.b;  x_in[2] = bus.c;  x_in[3] = bus.d;
        w_in[0] = bus.w0; w_in[1] = bus.w1; w_in[2] = bus.w2; w_in[3] = bus.w3;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mult
            complex_mult #(.WIDTH(HW)) u_mult (
                .x (x_in[gi]),
                .w (w_in[gi]),
                .p (prod[gi])
            );
        end
    endgenerate

    always_comb begin
        valid_s1_d = bus.in_valid;
        for (int k = 0; k < 4; k++)
            prod_d[k] = bus.in_valid ? prod[k] : prod_q[k];
    end

    // The +-j terms are part swaps with a sign flip, so they appear as Bi/Di below.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            pr[k] = SW'($signed(prod_q[k][FULL_WIDTH-1:HW]));
            pi[k] = SW'($signed(prod_q[k][HW-1:0]));
        end
        sr[0] = pr[0] + pr[1] + pr[2] + pr[3];
        si[0] = pi[0] + pi[1] + pi[2] + pi[3];
        sr[1] = pr[0] + pi[1] - pr[2] - pi[3];
        si[1] = pi[0] - pr[1] - pi[2] + pr[3];
        sr[2] = pr[0] - pr[1] + pr[2] - pr[3];
        si[2] = pi[0] - pi[1] + pi[2] - pi[3];
        sr[3] = pr[0] - pi[1] - pr[2] + pi[3];
        si[3] = pi[0] + pr[1] - pi[2] - pr[3];

        out_valid_d = valid_s1_q;
        for (int k = 0; k < 4; k++) begin
            if (valid_s1_q)
                out_d[k] = {HW'(sat(64'(sr[k]), HW)), HW'(sat(64'(si[k]), HW))};
            else
                out_d[k] = out_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1_q  <= 1'b0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                prod_q[k] <= '0;
                out_q[k]  <= '0;
            end
        end else begin
            valid_s1_q  <= valid_s1_d;
            out_valid_q <= out_valid_d;
            for (int k = 0; k < 4; k++) begin
                prod_q[k] <= prod_d[k];
                out_q[k]  <= out_d[k];
            end
        end
    end

    assign bus.out0      = out_q[0];
    assign bus.out1      = out_q[1];
    assign bus.out2      = out_q[2];
    assign bus.out3      = out_q[3];
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_butterfly_radix4.sv
// Bench for butterfly_radix4: fixed vectors, streaming, mid-stream reset and random
// traffic against a DFT-style reference (out_k = sum_m P_m * (-j)^(k*m)).
module tb_butterfly_radix4;
    import fft_pkg::*;

    typedef logic [3:0][31:0] quad_t;
    typedef struct {
        quad_t s;
        quad_t w;
        quad_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    butterfly_radix4_if #(.FULL_WIDTH(32)) bus ();

    butterfly_radix4 #(.FULL_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    bit    p1_v, p2_v;
    quad_t p1_e, p2_e, held;
    quad_t idle = '0;
    vec_t  tbl [4];

    function automatic logic [31:0] cx(input int re, input int im);
        return {re[15:0], im[15:0]};
    endfunction

    function automatic longint clamp16(input longint x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic quad_t model(input quad_t s, input quad_t w);
        longint pr [4];
        longint pim [4];
        longint xr, xi, wr, wi, tr, ti, t, acc_r, acc_i;
        quad_t  res;
        for (int m = 0; m < 4; m++) begin
            xr = longint'($signed(s[m][31:16]));
            xi = longint'($signed(s[m][15:0]));
            wr = longint'($signed(w[m][31:16]));
            wi = longint'($signed(w[m][15:0]));
            pr[m]  = clamp16((xr * wr - xi * wi + 16384) >>> 15);
            pim[m] = clamp16((xr * wi + xi * wr + 16384) >>> 15);
        end
        for (int k = 0; k < 4; k++) begin
            acc_r = 0;
            acc_i = 0;
            for (int m = 0; m < 4; m++) begin
                tr = pr[m];
                ti = pim[m];
                for (int r = 0; r < (k * m) % 4; r++) begin
                    t  = tr;
                    tr = ti;
                    ti = -t;
                end
                acc_r += tr;
                acc_i += ti;
            end
            res[k] = {16'(clamp16(acc_r)), 16'(clamp16(acc_i))};
        end
        return res;
    endfunction

    task automatic check(input string what, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", what, $time, got, exp);
        end
    endtask

    task automatic drive(input bit v, input quad_t s, input quad_t w);
        bus.in_valid = v;
        bus.a  = s[0]; bus.b  = s[1]; bus.c  = s[2]; bus.d  = s[3];
        bus.w0 = w[0]; bus.w1 = w[1]; bus.w2 = w[2]; bus.w3 = w[3];
    endtask

    task automatic sb_clear();
        p1_v = 1'b0; p2_v = 1'b0;
        p1_e = '0;   p2_e = '0;   held = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        check({tag, "_out0"}, bus.out0, 32'd0);
        check({tag, "_out1"}, bus.out1, 32'd0);
        check({tag, "_out2"}, bus.out2, 32'd0);
        check({tag, "_out3"}, bus.out3, 32'd0);
    endtask

    // One clock: compare outputs against the input of two cycles ago, then drive.
    task automatic step(input bit v, input quad_t s, input quad_t w, input quad_t e);
        quad_t got, exp_d;
        @(posedge clk);
        #1;
        got = {bus.out3, bus.out2, bus.out1, bus.out0};
        check("out_valid", {31'b0, bus.out_valid}, {31'b0, p2_v});
        exp_d = p2_v ? p2_e : held;
        held  = exp_d;
        for (int k = 0; k < 4; k++)
            check($sformatf("out%0d", k), got[k], exp_d[k]);
        drive(v, s, w);
        p2_v = p1_v; p2_e = p1_e;
        p1_v = v;    p1_e = e;
    endtask

    initial begin
        tbl[0].s = {cx(250, 0), cx(200, 0), cx(150, 0), cx(100, 0)};
        tbl[0].w = {W0_4, W0_4, W0_4, W0_4};
        tbl[0].e = {cx(-100, -100), cx(-100, 0), cx(-100, 100), cx(700, 0)};
        tbl[1].s = tbl[0].s;
        tbl[1].w = {W0_4, W0_4, W1_4, W0_4};
        tbl[1].e = {cx(50, -250), cx(50, 150), cx(-250, 250), cx(550, -150)};
        tbl[2].s = {cx(32767, 0), cx(32767, 0), cx(32767, 0), cx(32767, 0)};
        tbl[2].w = {W0_4, W0_4, W0_4, W0_4};
        tbl[2].e = {cx(0, 0), cx(0, 0), cx(0, 0), cx(32767, 0)};
        tbl[3].s = {cx(0, 0), cx(0, 0), cx(0, 0), cx(-32768, 0)};
        tbl[3].w = {W0_4, W0_4, W0_4, W2_4};
        tbl[3].e = {cx(32767, 0), cx(32767, 0), cx(32767, 0), cx(32767, 0)};

        rst_n = 1'b0;
        drive(1'b0, idle, idle);
        sb_clear();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            step(1'b1, tbl[i].s, tbl[i].w, tbl[i].e);
            repeat (3) step(1'b0, idle, idle, idle);
            $display("vector %0d: out0=%h out1=%h out2=%h out3=%h", i,
                     tbl[i].e[0], tbl[i].e[1], tbl[i].e[2], tbl[i].e[3]);
        end

        step(1'b1, tbl[0].s, tbl[0].w, tbl[0].e);
        step(1'b1, tbl[1].s, tbl[1].w, tbl[1].e);
        step(1'b0, idle, idle, idle);
        step(1'b1, tbl[0].s, tbl[0].w, tbl[0].e);
        repeat (3) step(1'b0, idle, idle, idle);
        $display("streaming sequence 1,1,0,1 done");

        step(1'b1, tbl[2].s, tbl[2].w, tbl[2].e);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(1'b0, idle, idle);
        #1;
        check_zero("midreset");
        sb_clear();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_zero("inreset");
        end
        rst_n = 1'b1;
        repeat (3) step(1'b0, idle, idle, idle);
        step(1'b1, tbl[1].s, tbl[1].w, tbl[1].e);
        repeat (3) step(1'b0, idle, idle, idle);
        $display("mid-stream reset sequence done");

        for (int n = 0; n < 300; n++) begin
            quad_t s, w;
            bit    v;
            v = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) begin
                s[k] = $urandom;
                case ($urandom_range(0, 4))
                    0:       w[k] = W1_4;
                    1:       w[k] = W2_4;
                    default: w[k] = $urandom;
                endcase
            end
            step(v, s, w, model(s, w));
        end
        repeat (3) step(1'b0, idle, idle, idle);
        $display("random stream done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
